// File: rtl/arb_pkg.sv
// Shared constants for the two-requester memory arbiter: FSM encoding,
// owner indices and the latency counter width.
package arb_pkg;

    localparam int LAT_W = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam logic OWNER_0 = 1'b0;
    localparam logic OWNER_1 = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational 2-way round-robin picker with a per-requester hold-off mask.
module rr_pick
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic [1:0] cand;

    assign cand = req & ~mask;

    always_comb begin
        gnt_valid = |cand;
        gnt_idx   = OWNER_0;
        unique case (cand)
            2'b01:   gnt_idx = OWNER_0;
            2'b10:   gnt_idx = OWNER_1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = OWNER_0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency synchronous memory
// port between two requesters. Define ARB_STATS_EN to add per-requester grant counters.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MEM_LAT = 2
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             wr0,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             req1,
    input  logic             wr1,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_wr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy,
`ifdef ARB_STATS_EN
    output logic [15:0]      gnt_cnt0,
    output logic [15:0]      gnt_cnt1,
`endif
    output logic             owner
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic [1:0]       mask_q, mask_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;

    logic gnt_valid;
    logic gnt_idx;

    rr_pick u_pick (
        .req       ({req1, req0}),
        .mask      (mask_q),
        .last      (owner_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        mask_d  = 2'b00;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_idx;
                    wr_d    = (gnt_idx == OWNER_1) ? wr1    : wr0;
                    addr_d  = (gnt_idx == OWNER_1) ? addr1  : addr0;
                    wdata_d = (gnt_idx == OWNER_1) ? wdata1 : wdata0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                // Mask the just-served requester for one IDLE cycle so it can drop req.
                mask_d  = (owner_q == OWNER_1) ? 2'b10 : 2'b01;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWNER_1;
            mask_q  <= 2'b00;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            mask_q  <= mask_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack0      = (state_q == ACK) && (owner_q == OWNER_0);
    assign ack1      = (state_q == ACK) && (owner_q == OWNER_1);
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wr    = (state_q == ISSUE) && wr_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt_q [2];
    logic [15:0] gnt_cnt_d [2];
    logic        issue_entry;

    assign issue_entry = (state_q == IDLE) && gnt_valid;

    for (genvar gi = 0; gi < 2; gi++) begin : g_stats
        always_comb begin
            gnt_cnt_d[gi] = gnt_cnt_q[gi];
            if (issue_entry && (gnt_idx == 1'(gi))) begin
                gnt_cnt_d[gi] = gnt_cnt_q[gi] + 16'd1;
            end
        end

        always_ff @(posedge Clock) begin
            if (reset) begin
                gnt_cnt_q[gi] <= '0;
            end else begin
                gnt_cnt_q[gi] <= gnt_cnt_d[gi];
            end
        end
    end

    assign gnt_cnt0 = gnt_cnt_q[0];
    assign gnt_cnt1 = gnt_cnt_q[1];
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected bus
// issues and acks; a negedge monitor models the memory and checks the DUT.
module tb_mem_arbiter;

    localparam int WIDTH   = 16;
    localparam int MEM_LAT = 2;

    logic             Clock = 1'b0;
    logic             reset = 1'b1;
    logic             req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
    logic [WIDTH-1:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic             ack0, ack1, mem_wr, busy, owner;
    logic [WIDTH-1:0] rdata, mem_addr, mem_wdata;
    logic [WIDTH-1:0] mem_rdata = 16'h0BAD;
`ifdef ARB_STATS_EN
    logic [15:0]      gnt_cnt0, gnt_cnt1;
`endif

    mem_arbiter #(.WIDTH(WIDTH), .MEM_LAT(MEM_LAT)) dut (
        .Clock     (Clock),
        .reset     (reset),
        .req0      (req0),
        .wr0       (wr0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .wr1       (wr1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
`ifdef ARB_STATS_EN
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
`endif
        .owner     (owner)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        own;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } iss_t;

    typedef struct packed {
        logic        own;
        logic [15:0] rdata;
    } ack_t;

    iss_t        exp_iss[$];
    ack_t        exp_ack[$];
    logic [15:0] mem_model [logic [15:0]];

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    int issue_cyc = 0;
    int wr_pulses = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_txn(input logic own, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rd_exp, input bit with_ack);
        iss_t i;
        ack_t a;
        i.own = own; i.wr = wr; i.addr = addr; i.wdata = wdata;
        exp_iss.push_back(i);
        if (with_ack) begin
            a.own = own; a.rdata = rd_exp;
            exp_ack.push_back(a);
        end
        $display("txn: requester %0d %s addr=0x%04h wdata=0x%04h expect rdata=0x%04h%s",
                 own, wr ? "write" : "read ", addr, wdata, rd_exp, with_ack ? "" : " (aborted)");
    endtask

    task automatic wait_ack(input int idx, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge Clock);
            if ((idx == 0) ? ack0 : ack1) seen = 1;
        end
        if (!seen) begin
            compared++;
            failed++;
            $display("FAIL %s: ack%0d absent after 60 cycles, required one pulse", nm, idx);
        end
    endtask

    initial forever begin
        @(posedge Clock);
        cyc++;
    end

    // Memory model and monitor: everything sampled mid-cycle on the falling edge.
    initial begin
        logic        busy_prev;
        logic        issue_now;
        bit          rd_pend;
        int          rd_cnt;
        logic [15:0] rd_addr;
        iss_t        ei;
        ack_t        ea;
        busy_prev = 0; rd_pend = 0; rd_cnt = 0; rd_addr = '0;
        forever begin
            @(negedge Clock);
            if (reset) begin
                busy_prev = 0;
                rd_pend   = 0;
                mem_rdata = 16'h0BAD;
            end else begin
                issue_now = busy && !busy_prev;
                if (rd_pend) begin
                    rd_cnt--;
                    if (rd_cnt == 0) begin
                        mem_rdata = mem_model.exists(rd_addr) ? mem_model[rd_addr] : 16'h0BAD;
                        rd_pend   = 0;
                    end
                end else begin
                    mem_rdata = 16'h0BAD;
                end
                if (mem_wr) begin
                    wr_pulses++;
                    check("mem_wr_only_in_issue", {31'd0, issue_now}, 32'd1);
                end
                if (issue_now) begin
                    issue_cyc = cyc;
                    if (mem_wr) mem_model[mem_addr] = mem_wdata;
                    else begin
                        rd_pend = 1; rd_cnt = MEM_LAT; rd_addr = mem_addr;
                    end
                    if (exp_iss.size() == 0) begin
                        compared++; failed++;
                        $display("FAIL unexpected_issue: addr=0x%04h owner=%0d, required no issue", mem_addr, owner);
                    end else begin
                        ei = exp_iss.pop_front();
                        check("issue_owner", {31'd0, owner}, {31'd0, ei.own});
                        check("issue_addr", {16'd0, mem_addr}, {16'd0, ei.addr});
                        check("issue_wdata", {16'd0, mem_wdata}, {16'd0, ei.wdata});
                        check("issue_wr", {31'd0, mem_wr}, {31'd0, ei.wr});
                    end
                end
                if (ack0 || ack1) begin
                    check("ack_onehot", {31'd0, ack0 & ack1}, 32'd0);
                    if (exp_ack.size() == 0) begin
                        compared++; failed++;
                        $display("FAIL unexpected_ack: ack0=%0d ack1=%0d, required none", ack0, ack1);
                    end else begin
                        ea = exp_ack.pop_front();
                        check("ack_index", {31'd0, ack1}, {31'd0, ea.own});
                        check("ack_rdata", {16'd0, rdata}, {16'd0, ea.rdata});
                        check("ack_latency", 32'(cyc - issue_cyc), 32'(MEM_LAT + 1));
                        $display("ack%0d at cycle %0d rdata=0x%04h", ack1, cyc, rdata);
                    end
                end
                busy_prev = busy;
            end
        end
    end

    initial begin
        int t0, a_cyc, n_acks, idle_cnt, acks_seen, wr_before;
        bit started;
        mem_model[16'h0010] = 16'hBEEF;
        mem_model[16'h0020] = 16'h0000;
        mem_model[16'h0030] = 16'hC0DE;
        mem_model[16'h0040] = 16'h5A5A;
        mem_model[16'h0050] = 16'h1111;

        repeat (3) @(negedge Clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_owner", {31'd0, owner}, 32'd1);
        check("rst_acks", {30'd0, ack1, ack0}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        reset = 0;

        // Single read from requester 0; inputs disturbed after grant.
        push_txn(0, 0, 16'h0010, 16'h7777, 16'hBEEF, 1);
        @(negedge Clock);
        req0 = 1; wr0 = 0; addr0 = 16'h0010; wdata0 = 16'h7777;
        t0 = cyc;
        @(negedge Clock);
        addr0 = 16'hFFFF; wr0 = 1;
        wait_ack(0, "read0_ack");
        check("read0_latency", 32'(cyc - t0), 32'(2 + MEM_LAT));
        req0 = 0; wr0 = 0;

        // Single write from requester 1.
        wr_before = wr_pulses;
        push_txn(1, 1, 16'h0020, 16'h1234, 16'hBEEF, 1);
        @(negedge Clock);
        req1 = 1; wr1 = 1; addr1 = 16'h0020; wdata1 = 16'h1234;
        wait_ack(1, "write1_ack");
        req1 = 0; wr1 = 0;
        check("write1_wr_pulses", 32'(wr_pulses - wr_before), 32'd1);

        // Both requesters held: strict alternation 0,1,0,1.
        push_txn(0, 0, 16'h0030, 16'h0000, 16'hC0DE, 1);
        push_txn(1, 0, 16'h0040, 16'h0000, 16'h5A5A, 1);
        push_txn(0, 0, 16'h0030, 16'h0000, 16'hC0DE, 1);
        push_txn(1, 0, 16'h0040, 16'h0000, 16'h5A5A, 1);
        @(negedge Clock);
        req0 = 1; addr0 = 16'h0030; wdata0 = 16'h0000;
        req1 = 1; addr1 = 16'h0040; wdata1 = 16'h0000;
        n_acks = 0; idle_cnt = 0; started = 0;
        for (int i = 0; i < 200 && n_acks < 4; i++) begin
            @(negedge Clock);
            if (busy) started = 1;
            else if (started) idle_cnt++;
            if (ack0 || ack1) n_acks++;
        end
        req0 = 0; req1 = 0;
        check("rr_ack_count", 32'(n_acks), 32'd4);
        check("rr_idle_gaps", 32'(idle_cnt), 32'd3);

        // Requester 0 keeps req high past its ack: hold-off delays the re-grant.
        push_txn(0, 0, 16'h0020, 16'h0000, 16'h1234, 1);
        push_txn(0, 0, 16'h0020, 16'h0000, 16'h1234, 1);
        @(negedge Clock);
        req0 = 1; addr0 = 16'h0020;
        wait_ack(0, "holdoff_first_ack");
        a_cyc = cyc;
        wait_ack(0, "holdoff_second_ack");
        req0 = 0;
        check("holdoff_spacing", 32'(issue_cyc - a_cyc), 32'd3);

`ifdef ARB_STATS_EN
        check("stats_gnt_cnt0", {16'd0, gnt_cnt0}, 32'd5);
        check("stats_gnt_cnt1", {16'd0, gnt_cnt1}, 32'd3);
`endif

        // Reset during WAIT aborts the transaction without an ack.
        push_txn(0, 0, 16'h0050, 16'h0000, 16'h0000, 0);
        @(negedge Clock);
        req0 = 1; addr0 = 16'h0050;
        started = 0;
        for (int i = 0; i < 20 && !started; i++) begin
            @(negedge Clock);
            if (busy) started = 1;
        end
        check("abort_reached_issue", {31'd0, started}, 32'd1);
        @(negedge Clock);
        reset = 1; req0 = 0;
        @(negedge Clock);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_owner", {31'd0, owner}, 32'd1);
        check("abort_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("abort_rdata", {16'd0, rdata}, 32'd0);
        reset = 0;
        acks_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (ack0 || ack1) acks_seen++;
        end
        check("abort_no_ack", 32'(acks_seen), 32'd0);

        push_txn(0, 0, 16'h0010, 16'h0000, 16'hBEEF, 1);
        req0 = 1; addr0 = 16'h0010;
        wait_ack(0, "post_reset_ack");
        req0 = 0;

        repeat (5) @(negedge Clock);
`ifdef ARB_STATS_EN
        check("stats_post_rst_cnt0", {16'd0, gnt_cnt0}, 32'd1);
        check("stats_post_rst_cnt1", {16'd0, gnt_cnt1}, 32'd0);
`endif
        check("leftover_issues", 32'(exp_iss.size()), 32'd0);
        check("leftover_acks", 32'(exp_ack.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
